// File: rtl/nibble_serial_adder.sv
// Nibble-serial word adder: one 4-bit slice per cycle, LS nibble first, valid/ready on both sides.
// Optional subtraction (A-B, cout=1 means no borrow) is compiled in with `define NSA_SUB_EN.

module four_bit_full_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [4:0] c;
    assign c[0] = c_i;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign c_o = c[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a_nib,
    input  logic [3:0] b_nib,
`ifdef NSA_SUB_EN
    input  logic       sub,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] sum_nib,
    output logic       out_last,
    output logic       cout,
    output logic [7:0] words_done
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q;
    logic          out_valid_q, out_last_q, cout_q;
    logic [3:0]    sum_q;
    logic [7:0]    words_q, words_d;
`ifdef NSA_SUB_EN
    logic          sub_q;
`endif

    logic       xfer, is_last, sub_eff, cin;
    logic [3:0] b_op, add_s;
    logic       add_c;

    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready;
    assign is_last  = (idx_q == LAST);

    // Nibble 0 takes the mode from the port; later nibbles use the latched mode.
    always_comb begin
`ifdef NSA_SUB_EN
        sub_eff = (state_q == IDLE) ? sub : sub_q;
`else
        sub_eff = 1'b0;
`endif
        b_op    = sub_eff ? ~b_nib : b_nib;
        cin     = (state_q == IDLE) ? sub_eff : carry_q;
        idx_d   = is_last ? '0 : idx_q + 1'b1;
        words_d = is_last ? words_q + 8'd1 : words_q;
    end

    four_bit_full_adder u_fa (
        .a_i (a_nib),
        .b_i (b_op),
        .c_i (cin),
        .s_o (add_s),
        .c_o (add_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= 4'd0;
            out_last_q  <= 1'b0;
            cout_q      <= 1'b0;
            words_q     <= 8'd0;
`ifdef NSA_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else if (xfer) begin
            sum_q       <= add_s;
            carry_q     <= add_c;
            out_valid_q <= 1'b1;
            out_last_q  <= is_last;
            cout_q      <= is_last ? add_c : 1'b0;
            idx_q       <= idx_d;
            words_q     <= words_d;
            state_q     <= is_last ? IDLE : RUN;
`ifdef NSA_SUB_EN
            if (state_q == IDLE) sub_q <= sub;
`endif
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign sum_nib    = sum_q;
    assign out_last   = out_last_q;
    assign cout       = cout_q;
    assign words_done = words_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder; expected sums come from whole-word arithmetic.
// Define NSA_SUB_EN here too when building the subtract variant.

module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;
`ifdef NSA_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, sub;
    logic [3:0] a_nib, b_nib;
    logic       in_ready, out_valid, out_last, cout;
    logic [3:0] sum_nib;
    logic [7:0] words_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] words_exp = 8'd0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_nib      (a_nib),
        .b_nib      (b_nib),
`ifdef NSA_SUB_EN
        .sub        (sub),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum_nib    (sum_nib),
        .out_last   (out_last),
        .cout       (cout),
        .words_done (words_done)
    );

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        logic [W:0] bb;
        bb = {1'b0, (s ? ~b : b)};
        return {1'b0, a} + bb + (W+1)'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Present nibble i, take one edge, check the registered result.
    task automatic send_nib(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        logic [W:0] e;
        e = model(a, b, s);
        in_valid = 1'b1;
        a_nib = a[4*i +: 4];
        b_nib = b[4*i +: 4];
        sub = (i == 0) ? s : 1'($urandom);
        #1 chk("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("sum_nib", 32'(sum_nib), 32'(e[4*i +: 4]));
        chk("out_last", 32'(out_last), 32'(i == N-1));
        chk("cout", 32'(cout), (i == N-1) ? 32'(e[W]) : 32'd0);
        if (i == N-1) begin
            words_exp++;
            chk("words_done", 32'(words_done), 32'(words_exp));
        end
    endtask

    task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                chk("gap_out_valid", 32'(out_valid), 32'd0);
            end
            send_nib(i, a, b, s);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W:0] e;
        logic [W-1:0] ra, rb;
        logic [3:0] held;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0;
        a_nib = 4'd0; b_nib = 4'd0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum_nib), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_words", 32'(words_done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_word(16'h1234, 16'h1111, 1'b0, 1'b0);
        run_word(16'hFFFF, 16'h0001, 1'b0, 1'b0);

        // Back-pressure after nibble 1: output must freeze and input must stall.
        ra = 16'($urandom); rb = 16'($urandom);
        e = model(ra, rb, 1'b0);
        send_nib(0, ra, rb, 1'b0);
        send_nib(1, ra, rb, 1'b0);
        held = sum_nib;
        out_ready = 1'b0;
        in_valid = 1'b1; a_nib = ra[11:8]; b_nib = rb[11:8];
        repeat (3) begin
            #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum_stable", 32'(sum_nib), 32'(e[7:4]));
            chk("bp_sum_held", 32'(sum_nib), 32'(held));
        end
        out_ready = 1'b1;
        send_nib(2, ra, rb, 1'b0);
        send_nib(3, ra, rb, 1'b0);
        in_valid = 1'b0;

        for (int k = 0; k < 8; k++)
            run_word(16'($urandom), 16'($urandom), HAS_SUB & 1'($urandom), 1'b1);

        if (HAS_SUB) run_word(16'h0005, 16'h0007, 1'b1, 1'b0);

        // Reset mid-word: partial word and stale carry must be dropped.
        send_nib(0, 16'hFFFF, 16'h0001, 1'b0);
        send_nib(1, 16'hFFFF, 16'h0001, 1'b0);
        send_nib(2, 16'hFFFF, 16'h0001, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum_nib), 32'd0);
        chk("mid_rst_words", 32'(words_done), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        words_exp = 8'd0;
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("mid_rst_rel_in_ready", 32'(in_ready), 32'd1);
        run_word(16'h0001, 16'h0001, 1'b0, 1'b0);

        while (words_exp != 8'd255)
            run_word(16'($urandom), 16'($urandom), HAS_SUB & 1'($urandom), 1'($urandom));
        run_word(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        chk("words_wrap", 32'(words_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand word (legal range 2..16).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 Port in_valid SHALL be an input, 1 bit wide: an operand nibble pair is present.
REQ-005 Port in_ready SHALL be an output, 1 bit wide: the block accepts the nibble pair this cycle.
REQ-006 Ports a_nib and b_nib SHALL be inputs, 4 bits wide each: operand nibbles, least-significant nibble first.
REQ-007 Port out_valid SHALL be an output, 1 bit wide: a sum nibble is held.
REQ-008 Port out_ready SHALL be an input, 1 bit wide: the consumer takes the sum nibble.
REQ-009 Port sum_nib SHALL be an output, 4 bits wide: the sum nibble.
REQ-010 Port out_last SHALL be an output, 1 bit wide: sum_nib is the final (most-significant) nibble of the word.
REQ-011 Port cout SHALL be an output, 1 bit wide: the word carry-out, meaningful only when out_valid and out_last are both 1.
REQ-012 Port words_done SHALL be an output, 8 bits wide: count of completed words, wrapping 255->0.

Function
REQ-013 Input handshake: a transfer SHALL occur when in_valid and in_ready are both 1; output handshake: a transfer SHALL occur when out_valid and out_ready are both 1.
REQ-014 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-015 The add SHALL be a 4-bit ripple addition of a_nib + b_nib + carry_reg; the existing four_bit_full_adder is the required datapath.
REQ-016 State IDLE (waiting for nibble 0): carry-in SHALL be 0 regardless of carry_reg.
REQ-017 State RUN (nibbles 1..NIBBLES-1): carry-in SHALL be carry_reg.
REQ-018 On every input transfer, sum_nib, out_last and cout SHALL be registered, and out_valid SHALL go to 1 on the next edge (latency 1 cycle).
REQ-019 On every input transfer, carry_reg SHALL take the adder carry-out.
REQ-020 Nibble counter idx (width clog2(NIBBLES)) SHALL increment on each input transfer.
REQ-021 On the transfer with idx==NIBBLES-1: out_last=1, cout=adder carry-out, idx wraps to 0, the state returns to IDLE, and words_done increments.
REQ-022 IDLE SHALL transition to RUN on an input transfer; RUN SHALL stay in RUN until the last-nibble transfer.
REQ-023 Without an input transfer, an output transfer SHALL clear out_valid; with simultaneous input and output transfers, out_valid SHALL stay 1 and carry the new data (full throughput, 1 nibble/cycle).
REQ-024 Output registers SHALL hold stable while out_valid=1 and out_ready=0 (back-pressure); no input is accepted then.
REQ-025 When out_last=0, cout SHALL be driven 0.

Reset
REQ-026 rst=1 SHALL asynchronously force: state=IDLE, idx=0, carry_reg=0, out_valid=0, sum_nib=0, out_last=0, cout=0, words_done=0.
REQ-027 Reset mid-word SHALL discard the partial word; the next accepted nibble is nibble 0 with carry-in 0.
REQ-028 in_ready SHALL be 1 during reset and on the first cycle after reset release.

Configuration
REQ-029 Macro NSA_SUB_EN SHALL select subtraction compiled in or out.
REQ-030 With NSA_SUB_EN defined, the block SHALL have an added 1-bit input sub, sampled on the nibble-0 transfer and held for the word.
REQ-031 With NSA_SUB_EN defined and sub=1, b_nib SHALL be inverted and nibble-0 carry-in SHALL be 1 (A-B), with cout=1 meaning no borrow.
REQ-032 Without NSA_SUB_EN, the sub port SHALL be absent and the block SHALL only add.

Verification
REQ-033 Bench SHALL cover: NIBBLES=4, A=0x1234, B=0x1111, continuous valid, out_ready=1 -> sum nibbles 5,4,3,2 on consecutive cycles, out_last on the 4th, cout=0, words_done=1.
REQ-034 Bench SHALL cover: A=0xFFFF, B=0x0001 -> sums 0,0,0,0, carry propagates each nibble, cout=1 with out_last.
REQ-035 Bench SHALL cover: out_ready held 0 for 3 cycles after nibble 1 -> in_ready=0, sum_nib stable; resume -> correct remaining nibbles, no loss or duplication.
REQ-036 Bench SHALL cover: rst pulsed after nibble 2 of A=0xFFFF+B=0x0001, then A=0x0001+B=0x0001 -> sums 2,0,0,0, cout=0 (no stale carry), words_done=1.
REQ-037 Bench SHALL cover: words_done at 255 plus one completed word -> words_done=0.
REQ-038 Bench SHALL cover, with NSA_SUB_EN: sub=1, A=0x0005, B=0x0007 -> sums E,F,F,F, cout=0.
